// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings,
// stall/flush bit positions and the canned stall/flush patterns.
// Optional feature macro used by pipe_ctrl: PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_HOLD      = 2'd2,
    ST_JUMP_PEND = 2'd3
  } state_t;

  // Bit positions inside stall_o
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;

  // Bit positions inside flush_o
  localparam int FLUSH_IF_ID = 0;
  localparam int FLUSH_ID_EX = 1;

  // Freeze every pipeline register
  localparam logic [3:0] STALL_ALL = 4'b1111;
  // Load-use: hold pc and if_id so the dependent instruction waits in ID
  localparam logic [3:0] STALL_LU  = 4'b0011;
  localparam logic [3:0] STALL_NONE = 4'b0000;

  // Redirect: squash both younger stages
  localparam logic [1:0] FLUSH_ALL  = 2'b11;
  // Load-use: bubble goes into id_ex while ID is held
  localparam logic [1:0] FLUSH_LU   = 2'b10;
  localparam logic [1:0] FLUSH_NONE = 2'b00;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl_lu_hazard.sv
// Load-use hazard detector: flags when the load in EX writes a register
// that the instruction in ID actually reads. x0 never creates a hazard.
module lu_hazard
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_re,
  input  logic [4:0] ex_rd_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_re,
  input  logic       rs2_re,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_re && (rs1_addr == ex_rd_addr);
  assign rs2_hit = rs2_re && (rs2_addr == ex_rd_addr);
  assign hazard  = ex_mem_re && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller. Mealy outputs from a 4-state FSM
// plus a pending-jump register that parks a redirect arriving during a
// memory wait. Optional performance counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_i,
  input  logic              ext_hold_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_rs1_re_i,
  input  logic              id_rs2_re_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_mem_re_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [3:0]        stall_o,
  output logic [1:0]        flush_o,
  output logic [1:0]        state_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] next_pend;
  logic              lu_hit;

  lu_hazard u_lu_hazard (
    .ex_mem_re  (ex_mem_re_i),
    .ex_rd_addr (ex_rd_addr_i),
    .rs1_addr   (id_rs1_addr_i),
    .rs2_addr   (id_rs2_addr_i),
    .rs1_re     (id_rs1_re_i),
    .rs2_re     (id_rs2_re_i),
    .hazard     (lu_hit)
  );

  // State and pending-jump register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      pend_addr <= '0;
    end else begin
      state     <= next_state;
      pend_addr <= next_pend;
    end
  end

  // Next state and Mealy outputs; everything forced quiet while in reset
  always_comb begin
    next_state  = state;
    next_pend   = pend_addr;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    stall_o     = STALL_NONE;
    flush_o     = FLUSH_NONE;
    if (rst_n) begin
      unique case (state)
        ST_RUN, ST_LU_STALL: begin
          next_state = ST_RUN;
          if (ext_hold_i && jump_en_i) begin
            stall_o    = STALL_ALL;
            next_pend  = jump_addr_i;
            next_state = ST_JUMP_PEND;
          end else if (ext_hold_i || hold_flag_i) begin
            stall_o    = STALL_ALL;
            next_state = ST_HOLD;
          end else if (jump_en_i) begin
            jump_en_o   = 1'b1;
            jump_addr_o = jump_addr_i;
            flush_o     = FLUSH_ALL;
          end else if (lu_hit && (state == ST_RUN)) begin
            stall_o    = STALL_LU;
            flush_o    = FLUSH_LU;
            next_state = ST_LU_STALL;
          end
        end
        ST_HOLD: begin
          if (hold_flag_i) begin
            stall_o = STALL_ALL;
          end else if (ext_hold_i && jump_en_i) begin
            stall_o    = STALL_ALL;
            next_pend  = jump_addr_i;
            next_state = ST_JUMP_PEND;
          end else if (ext_hold_i) begin
            stall_o = STALL_ALL;
          end else begin
            next_state = ST_RUN;
            if (jump_en_i) begin
              jump_en_o   = 1'b1;
              jump_addr_o = jump_addr_i;
              flush_o     = FLUSH_ALL;
            end
          end
        end
        ST_JUMP_PEND: begin
          if (ext_hold_i) begin
            stall_o = STALL_ALL;
          end else begin
            jump_en_o   = 1'b1;
            jump_addr_o = pend_addr;
            flush_o     = FLUSH_ALL;
            next_state  = ST_RUN;
          end
        end
      endcase
    end
  end

  assign state_o = rst_n ? state : ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Saturating counters of stalled cycles and redirects
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o[STALL_PC] && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 32'd1;
      if (jump_en_o && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = rst_n ? stall_cnt : '0;
  assign flush_cnt_o = rst_n ? flush_cnt : '0;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
